// File: rtl/lsl32_seq_pkg.sv
// Shared constants for the 32-bit sequential shift family.
// Holds the FSM state encodings, the mode codes and the fixed widths.
// Also provides the per-cycle step-size helper used by the shift controller.
package lsl32_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic MODE_LSL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

  // Largest step the datapath can take in one cycle is 3 bits.
  function automatic logic [1:0] step_of(input logic [SHAMT_W-1:0] rem);
    if (rem > SHAMT_W'(3)) begin
      return 2'd3;
    end
    return rem[1:0];
  endfunction

endpackage

// File: rtl/lsl32_seq_shl_step.sv
// Combinational 0..3-bit left shift / rotate stage.
// mx4     : single-bit 4-to-1 multiplexer.
// shl_step: 32 mx4 instances, one per result bit.
//   din  [31:0] operand
//   amt  [1:0]  shift distance 0..3
//   mode        MODE_LSL zero-fills, MODE_ROL wraps bit 31 into bit 0
//   dout [31:0] shifted result
module mx4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  assign y = d[sel];
endmodule

module shl_step
  import lsl32_seq_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        amt,
  input  logic              mode,
  output logic [DATA_W-1:0] dout
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic [3:0] cand;
    for (genvar k = 0; k < 4; k++) begin : g_cand
      if (i >= k) begin : g_in
        assign cand[k] = din[i-k];
      end else begin : g_wrap
        // Vacated low bits take the bits leaving the top only when rotating.
        assign cand[k] = (mode == MODE_ROL) & din[DATA_W+i-k];
      end
    end
    mx4 u_mx4 (
      .d   (cand),
      .sel (amt),
      .y   (dout[i])
    );
  end

endmodule

// File: rtl/lsl32_seq.sv
// Sequential 32-bit logical shift left / rotate left by 0..31.
// Accepts an operand in IDLE, shifts it up to 3 bits per cycle in SHIFT,
// then pulses done for one cycle in DONE while d_out holds the result.
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    request strobe, only honoured in IDLE
//   mode     0 = logical shift left, 1 = rotate left
//   d_in     operand, captured with start
//   shamt    shift amount, captured with start
//   d_out    result register
//   busy     high while shifting
//   done     one-cycle completion pulse
module lsl32_seq
  import lsl32_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [DATA_W-1:0]  d_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  d_out,
  output logic               busy,
  output logic               done
);

  state_t             state;
  state_t             state_nxt;
  logic [SHAMT_W-1:0] rem;
  logic               mode_r;
  logic [1:0]         step;
  logic [DATA_W-1:0]  shifted;

  assign step = step_of(rem);

  shl_step u_shl_step (
    .din  (d_out),
    .amt  (step),
    .mode (mode_r),
    .dout (shifted)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (rem == SHAMT_W'(step)) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      d_out  <= '0;
      rem    <= '0;
      mode_r <= MODE_LSL;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            d_out  <= d_in;
            rem    <= shamt;
            mode_r <= mode;
          end
        end
        ST_SHIFT: begin
          d_out <= shifted;
          rem   <= rem - SHAMT_W'(step);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
